// File: rtl/sel_code_pkg.sv
// -----------------------------------------------------------------------------
// sel_code_pkg
//   Shared types and helpers for the selector-code sequencer.
//   - state_t   : sequencer FSM states (IDLE / RUN / DONE)
//   - SEL_00..SEL_11 : named 2-bit selector codes
//   - next_code : successor of a selector code within a burst
//   - norm_code : maps a configured start code onto the legal code set
//   Configuration macro: SEL_SKIP_ILLEGAL_EN
//     defined     -> code 11 is never produced (00->01->10->00), start 11 acts as 00
//     not defined -> full 4-code cycle 00->01->10->11->00
// -----------------------------------------------------------------------------
package sel_code_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] SEL_00 = 2'b00;
   localparam logic [1:0] SEL_01 = 2'b01;
   localparam logic [1:0] SEL_10 = 2'b10;
   localparam logic [1:0] SEL_11 = 2'b11;

   // Successor code; wraps modulo 4, or modulo 3 when 11 is excluded.
   function automatic logic [1:0] next_code(input logic [1:0] code);
      logic [1:0] nxt;
`ifdef SEL_SKIP_ILLEGAL_EN
      if (code >= SEL_10) begin
         nxt = SEL_00;
      end else begin
         nxt = code + 2'b01;
      end
`else
      nxt = code + 2'b01;
`endif
      return nxt;
   endfunction

   // Start code actually used by the sequencer.
   function automatic logic [1:0] norm_code(input logic [1:0] code);
      logic [1:0] res;
`ifdef SEL_SKIP_ILLEGAL_EN
      if (code == SEL_11) begin
         res = SEL_00;
      end else begin
         res = code;
      end
`else
      res = code;
`endif
      return res;
   endfunction

endpackage

// File: rtl/sel_code_sequencer.sv
// -----------------------------------------------------------------------------
// sel_code_sequencer
//   Emits a burst of 2-bit selector codes on a valid/ready port for the
//   downstream 2-bit case decoder. A start command loads the burst length;
//   codes step from START_CODE, one per accepted transfer. A one-cycle done
//   pulse follows completion or abort; emitted_o reports accepted codes.
//
//   Parameters
//     CNT_W       width of burst length / emitted counter
//     START_CODE  first code of every burst
//   Ports
//     clk          clock, rising edge
//     rst_n        asynchronous active-low reset
//     start_i      burst request, honoured only in IDLE
//     len_i        burst length, sampled with start_i (0 = empty burst)
//     abort_i      terminate a running burst
//     sel_o        selector code
//     sel_valid_o  sel_o valid
//     sel_ready_i  downstream accepts sel_o
//     busy_o       high while in RUN or DONE
//     done_o       one-cycle completion pulse (cycle after DONE)
//     emitted_o    codes accepted in current / last burst
//   Configuration macro: SEL_SKIP_ILLEGAL_EN (see sel_code_pkg)
// -----------------------------------------------------------------------------
module sel_code_sequencer
   import sel_code_pkg::*;
#(
   parameter int         CNT_W      = 8,
   parameter logic [1:0] START_CODE = 2'b00
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             abort_i,
   output logic [1:0]       sel_o,
   output logic             sel_valid_o,
   input  logic             sel_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] emitted_o
);

   localparam logic [1:0]       START_EFF = norm_code(START_CODE);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic [CNT_W-1:0] remaining_r;
   logic [CNT_W-1:0] emitted_r;
   logic [1:0]       sel_r;
   logic             sel_valid_r;
   logic             busy_r;
   logic             done_r;

   logic             xfer_s;
   logic             last_s;

   // Handshake decode: a transfer happens when the offered code is accepted.
   always_comb begin
      xfer_s = 1'b0;
      last_s = 1'b0;
      if (state_r == RUN) begin
         xfer_s = sel_valid_r & sel_ready_i;
         last_s = (remaining_r == CNT_ONE);
      end else begin
         xfer_s = 1'b0;
         last_s = 1'b0;
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         remaining_r <= CNT_ZERO;
         emitted_r   <= CNT_ZERO;
         sel_r       <= START_EFF;
         sel_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_i) begin
                  emitted_r <= CNT_ZERO;
                  sel_r     <= START_EFF;
                  busy_r    <= 1'b1;
                  if (len_i != CNT_ZERO) begin
                     state_r     <= RUN;
                     remaining_r <= len_i;
                     sel_valid_r <= 1'b1;
                  end else begin
                     // Empty burst: straight to DONE without offering a code.
                     state_r     <= DONE;
                     remaining_r <= CNT_ZERO;
                     sel_valid_r <= 1'b0;
                  end
               end else begin
                  state_r     <= IDLE;
                  sel_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end
            RUN: begin
               if (xfer_s) begin
                  emitted_r   <= emitted_r + CNT_ONE;
                  remaining_r <= remaining_r - CNT_ONE;
               end else begin
                  emitted_r   <= emitted_r;
                  remaining_r <= remaining_r;
               end
               // Abort wins over advancing, but a same-cycle transfer was still counted above.
               if ((xfer_s && last_s) || abort_i) begin
                  state_r     <= DONE;
                  sel_valid_r <= 1'b0;
               end else if (xfer_s) begin
                  sel_r <= next_code(sel_r);
               end else begin
                  // Stall: code and valid stay put until accepted.
                  sel_r <= sel_r;
               end
            end
            DONE: begin
               state_r     <= IDLE;
               done_r      <= 1'b1;
               sel_valid_r <= 1'b0;
               sel_r       <= START_EFF;
               remaining_r <= CNT_ZERO;
               busy_r      <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               sel_valid_r <= 1'b0;
               sel_r       <= START_EFF;
               remaining_r <= CNT_ZERO;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign sel_o       = sel_r;
   assign sel_valid_o = sel_valid_r;
   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign emitted_o   = emitted_r;

endmodule
